// File: rtl/mem_stage.sv
// mem_stage: EX/MEM pipeline register with byte-addressable data memory and load extension
module mem_stage #(
  parameter int DM_WORDS = 1024,
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] instructure_in,
  input  logic [5:0]  instr_code_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] reg_read_data2_in,
  input  logic        mem_write_in,
  input  logic        mem_read_in,
  input  logic [1:0]  mem_size_in,
  input  logic        mem_unsigned_in,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instructure_out,
  output logic [5:0]  instr_code_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_read_data_out,
  output logic        misalign_out
);
  logic        valid, committed, wr, rd, uns;
  logic [1:0]  size;
  logic [5:0]  code;
  logic [31:0] pc, instr, alu, wdata;
  logic [31:0] mem [DM_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]  off;
  logic        mis_raw, store_en;
  logic [3:0]  be;
  logic [31:0] rword, wword, mask, merged;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ld_ext;
  assign idx = alu[AW+1:2];
  assign off = alu[1:0];
  assign rword = mem[idx];
  assign mis_raw = size == 2'b00 ? 1'b0 : size == 2'b01 ? off[0] : off != 2'b00;
  assign store_en = valid & wr & ~mis_raw & ~committed;
  assign be = size == 2'b00 ? 4'b0001 << off : size == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wword = size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
  assign mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign merged = (rword & ~mask) | (wword & mask);
  assign bsel = rword[{off, 3'b000} +: 8];
  assign hsel = off[1] ? rword[31:16] : rword[15:0];
  assign ld_ext = size == 2'b00 ? {{24{~uns & bsel[7]}}, bsel} :
                  size == 2'b01 ? {{16{~uns & hsel[15]}}, hsel} : rword;
  assign valid_out = valid;
  assign pc_out = pc;
  assign instructure_out = instr;
  assign instr_code_out = code;
  assign alu_result_out = alu;
  assign misalign_out = valid & (wr | rd) & mis_raw;
  assign mem_read_data_out = valid & rd & ~wr & ~mis_raw ? ld_ext : 32'h0;
  // EX/MEM register: reset and flush insert a zeroed bubble, stall holds and remembers a done store
  always_ff @(posedge clk) begin
    if (reset || flush_in) begin
      valid <= 1'b0;
      committed <= 1'b0;
      pc <= '0;
      instr <= '0;
      code <= '0;
      alu <= '0;
      wdata <= '0;
      wr <= 1'b0;
      rd <= 1'b0;
      size <= '0;
      uns <= 1'b0;
    end else if (stall_in) begin
      committed <= committed | store_en;
    end else begin
      valid <= 1'b1;
      committed <= 1'b0;
      pc <= pc_in;
      instr <= instructure_in;
      code <= instr_code_in;
      alu <= alu_result_in;
      wdata <= reg_read_data2_in;
      wr <= mem_write_in;
      rd <= mem_read_in;
      size <= mem_size_in;
      uns <= mem_unsigned_in;
    end
  end
  for (genvar g = 0; g < DM_WORDS; g++) begin : g_word
    // each word clears on reset and takes the lane-merged store data when addressed
    always_ff @(posedge clk) begin
      if (reset) mem[g] <= '0;
      else if (store_en && idx == AW'(g)) mem[g] <= merged;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven check of mem_stage stores, loads, extension, misalignment, stall, flush and reset
module tb_mem_stage;
  logic        clk = 1'b0, reset, stall_in, flush_in;
  logic [31:0] pc_in, instructure_in, alu_result_in, reg_read_data2_in;
  logic [5:0]  instr_code_in;
  logic        mem_write_in, mem_read_in, mem_unsigned_in;
  logic [1:0]  mem_size_in;
  logic        valid_out, misalign_out;
  logic [31:0] pc_out, instructure_out, alu_result_out, mem_read_data_out;
  logic [5:0]  instr_code_out;
  int checks = 0, failures = 0, writes = 0;

  typedef struct {
    logic wr, rd;
    logic [1:0] size;
    logic uns;
    logic [31:0] addr, data, exp_rd;
    logic exp_mis;
  } vec_t;
  vec_t v[23];

  mem_stage dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .pc_in(pc_in), .instructure_in(instructure_in), .instr_code_in(instr_code_in),
    .alu_result_in(alu_result_in), .reg_read_data2_in(reg_read_data2_in),
    .mem_write_in(mem_write_in), .mem_read_in(mem_read_in), .mem_size_in(mem_size_in),
    .mem_unsigned_in(mem_unsigned_in), .valid_out(valid_out), .pc_out(pc_out),
    .instructure_out(instructure_out), .instr_code_out(instr_code_out),
    .alu_result_out(alu_result_out), .mem_read_data_out(mem_read_data_out),
    .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data, input logic [31:0] pc);
    mem_write_in = wr;
    mem_read_in = rd;
    mem_size_in = size;
    mem_unsigned_in = uns;
    alu_result_in = addr;
    reg_read_data2_in = data;
    pc_in = pc;
    instructure_in = pc ^ 32'hA5000000;
    instr_code_in = pc[7:2];
  endtask

  initial begin
    v[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    v[1]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    v[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h21,   32'hAAAAAA80, 32'h0,        1'b0};
    v[3]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h21,   32'h0,        32'hFFFFFF80, 1'b0};
    v[4]  = '{1'b0, 1'b1, 2'd0, 1'b1, 32'h21,   32'h0,        32'h00000080, 1'b0};
    v[5]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h20,   32'h0,        32'h00008000, 1'b0};
    v[6]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h32,   32'h55551234, 32'h0,        1'b0};
    v[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h32,   32'h0,        32'h00001234, 1'b0};
    v[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h30,   32'h0,        32'h12340000, 1'b0};
    v[9]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h32,   32'h00008001, 32'h0,        1'b0};
    v[10] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h32,   32'h0,        32'hFFFF8001, 1'b0};
    v[11] = '{1'b0, 1'b1, 2'd1, 1'b1, 32'h32,   32'h0,        32'h00008001, 1'b0};
    v[12] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h41,   32'hCAFEF00D, 32'h0,        1'b1};
    v[13] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h43,   32'h0,        32'h0,        1'b1};
    v[14] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h40,   32'h0,        32'h0,        1'b0};
    v[15] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h1010, 32'h0,        32'hDEADBEEF, 1'b0};
    v[16] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h50,   32'h11223344, 32'h0,        1'b0};
    v[17] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h50,   32'h0,        32'h11223344, 1'b0};
    v[18] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h23,   32'h1234567F, 32'h0,        1'b0};
    v[19] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h23,   32'h0,        32'h0000007F, 1'b0};
    v[20] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h20,   32'h0,        32'h7F008000, 1'b0};
    v[21] = '{1'b0, 1'b1, 2'd3, 1'b0, 32'h20,   32'h0,        32'h7F008000, 1'b0};
    v[22] = '{1'b0, 1'b1, 2'd3, 1'b0, 32'h22,   32'h0,        32'h0,        1'b1};

    reset = 1'b1;
    stall_in = 1'b0;
    flush_in = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(valid_out), 32'h0);
    check("reset_pc", pc_out, 32'h0);
    check("reset_instr", instructure_out, 32'h0);
    check("reset_code", 32'(instr_code_out), 32'h0);
    check("reset_alu", alu_result_out, 32'h0);
    check("reset_rdata", mem_read_data_out, 32'h0);
    check("reset_mis", 32'(misalign_out), 32'h0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk) drive(v[i].wr, v[i].rd, v[i].size, v[i].uns, v[i].addr, v[i].data, 32'h100 + 32'(i) * 4);
      @(posedge clk) #1;
      check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'h1);
      check($sformatf("vec%0d_pc", i), pc_out, 32'h100 + 32'(i) * 4);
      check($sformatf("vec%0d_instr", i), instructure_out, (32'h100 + 32'(i) * 4) ^ 32'hA5000000);
      check($sformatf("vec%0d_alu", i), alu_result_out, v[i].addr);
      check($sformatf("vec%0d_rdata", i), mem_read_data_out, v[i].exp_rd);
      check($sformatf("vec%0d_mis", i), 32'(misalign_out), 32'(v[i].exp_mis));
    end

    @(negedge clk) drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h60, 32'hA5A5A5A5, 32'h200);
    @(posedge clk) #1;
    check("stall_latch_valid", 32'(valid_out), 32'h1);
    @(negedge clk);
    writes += int'(dut.store_en);
    stall_in = 1'b1;
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h70, 32'h0, 32'h300);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk) #1;
      check($sformatf("stall%0d_pc", c), pc_out, 32'h200);
      check($sformatf("stall%0d_alu", c), alu_result_out, 32'h60);
      check($sformatf("stall%0d_valid", c), 32'(valid_out), 32'h1);
      @(negedge clk);
      writes += int'(dut.store_en);
    end
    stall_in = 1'b0;
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h60, 32'h0, 32'h304);
    @(posedge clk) #1;
    check("stall_write_count", 32'(writes), 32'h1);
    check("stall_load_pc", pc_out, 32'h304);
    check("stall_load_rdata", mem_read_data_out, 32'hA5A5A5A5);

    @(negedge clk);
    stall_in = 1'b1;
    flush_in = 1'b1;
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h64, 32'h12345678, 32'h308);
    @(posedge clk) #1;
    check("flush_valid", 32'(valid_out), 32'h0);
    check("flush_pc", pc_out, 32'h0);
    check("flush_alu", alu_result_out, 32'h0);
    check("flush_rdata", mem_read_data_out, 32'h0);
    check("flush_mis", 32'(misalign_out), 32'h0);
    @(negedge clk);
    stall_in = 1'b0;
    flush_in = 1'b0;
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h64, 32'h0, 32'h30C);
    @(posedge clk) #1;
    check("flush_nowrite_valid", 32'(valid_out), 32'h1);
    check("flush_nowrite_rdata", mem_read_data_out, 32'h0);

    @(negedge clk) drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h68, 32'h99999999, 32'h310);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    stall_in = 1'b1;
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h68, 32'h0, 32'h314);
    @(posedge clk) #1;
    check("rst_store_valid", 32'(valid_out), 32'h0);
    check("rst_store_pc", pc_out, 32'h0);
    check("rst_store_alu", alu_result_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    stall_in = 1'b0;
    @(posedge clk) #1;
    check("rst_store_load_valid", 32'(valid_out), 32'h1);
    check("rst_store_load_rdata", mem_read_data_out, 32'h0);
    @(negedge clk) drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 32'h318);
    @(posedge clk) #1;
    check("rst_cleared_rdata", mem_read_data_out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- EX/MEM pipeline register plus data memory.
- Consumes the EX stage outputs (pc, instruction, instr_code, ALU result, rs/rt data) and produces load data and pass-through fields for the WB stage.
- Handles word, half and byte stores and loads, and sign- or zero-extends load data.
- Supports pipeline hold (stall) and bubble insertion (flush).

Parameters:
- DM_WORDS, 1024, number of 32-bit words in data memory (power of two).
- AW, 10, word-index width, equal to log2(DM_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall_in  in  1  hold the EX/MEM register.
- flush_in  in  1  load a bubble into the EX/MEM register.
- pc_in  in  32  pc from EX.
- instructure_in  in  32  instruction from EX.
- instr_code_in  in  6  decoded instruction code from EX.
- alu_result_in  in  32  ALU result; this is the memory address for loads and stores.
- reg_read_data2_in  in  32  rt data; this is the store data.
- mem_write_in  in  1  instruction is a store.
- mem_read_in  in  1  instruction is a load.
- mem_size_in  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- mem_unsigned_in  in  1  zero-extend load data (lbu/lhu).
- valid_out  out  1  MEM slot holds a real instruction.
- pc_out  out  32  latched pc.
- instructure_out  out  32  latched instruction.
- instr_code_out  out  6  latched instruction code.
- alu_result_out  out  32  latched ALU result.
- mem_read_data_out  out  32  extended load data; 0 when the slot is not a valid aligned load.
- misalign_out  out  1  latched access is misaligned.

Behaviour:
- EX/MEM register update at each rising edge, highest priority first:
  - reset: all fields 0, valid 0, committed 0.
  - flush_in: valid 0; other fields 0.
  - stall_in: hold all fields.
  - otherwise: capture all *_in inputs, set valid 1, committed 0.
- Reset and flush win over stall when asserted together.
- All outputs are driven from latched fields, so EX-to-output latency is 1 cycle. mem_read_data_out is combinational from the latched address and the memory array.
- Address decoding:
  - word index = latched alu_result[AW+1:2]; upper bits are ignored, so addresses wrap modulo DM_WORDS*4.
  - byte offset = alu_result[1:0].
  - Byte lanes are little-endian: offset 0 is bits 7:0.
- Misalignment rules:
  - Half access is misaligned when offset[0]=1.
  - Word access is misaligned when offset != 0.
  - Byte access is never misaligned.
  - misalign_out = valid & (write | read) & misaligned.
- Store rules:
  - A store executes at the rising edge ending the MEM cycle when valid & mem_write & !misalign & !committed & !reset.
  - Only the addressed lanes are written: byte writes data[7:0] into the selected lane; half writes data[15:0] into lanes {offset[1],0} and {offset[1],1}; word writes all four lanes.
  - After the write, committed is set to 1.
  - While stalled, committed stays 1, so a held store is written exactly once.
  - A misaligned store writes nothing.
- Load rules:
  - Read the whole word, select the lane(s), then extend.
  - Sign-extend from bit 7 (byte) or bit 15 (half) unless mem_unsigned is set; in that case zero-extend.
  - A misaligned load returns 0.
- Load after store, same address: the earlier store writes at the edge, and the following load in MEM the next cycle reads the new data. No bypass is needed.
- Reset clears all DM_WORDS memory words to 0 in the same edge.
- Reset mid-store: reset wins. That store is not written, and memory is cleared.
- A bubble (valid 0) never writes memory. Its outputs are 0 and misalign_out is 0.
- mem_write and mem_read both set: treated as a store; mem_read_data_out is 0.

Test Plan:
- Word store 0xDEADBEEF to 0x10, then lw 0x10 on the next instruction -> cycle after latch, mem_read_data_out=0xDEADBEEF and valid_out=1.
- sb 0x80 to 0x21, then lb 0x21 and lbu 0x21 -> 0xFFFFFF80 and 0x00000080; lw 0x20 -> 0x00008000.
- sh 0x1234 to 0x32, then lh 0x32 -> 0x00001234; lw 0x30 -> 0x12340000; sh 0x8001 to 0x32, then lh -> 0xFFFF8001.
- sw to 0x41, lh 0x43 -> misalign_out=1, memory word 0x40 unchanged, mem_read_data_out=0.
- Stall a latched sw for 3 cycles, and have the testbench overwrite that word in between via a second path or assertion probe -> exactly one write occurs (committed flag); outputs held for 3 cycles.
- flush_in with stall_in on the same edge -> valid_out=0 and no write. reset asserted with a pending sw -> all outputs 0 and the memory word reads 0 afterwards.
